// File: rtl/main_mem_pkg.sv
// main_mem_pkg
//   Shared types and sizing helpers for the main-memory model/controller.
//   - state_t      : controller FSM states
//   - *_DEF        : default geometry / latency values used by the modules
//   - OFF_W, BLK_W, BE_W, CNT_W : derived widths for the default geometry
//   - off_width()/cnt_width()   : helpers so overridden parameters derive
//                                 consistent widths inside the modules
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int ADDR_W_DEF          = 8;
  localparam int WORD_W_DEF          = 32;
  localparam int WORDS_PER_BLOCK_DEF = 4;
  localparam int READ_LAT_DEF        = 4;
  localparam int WRITE_LAT_DEF       = 3;

  // Word-offset width; a one-word block still gets a 1-bit offset port.
  function automatic int off_width(input int words_per_block);
    return (words_per_block > 1) ? $clog2(words_per_block) : 1;
  endfunction

  // The latency counter only ever holds LAT-1, so it needs clog2(max LAT)
  // bits, with a floor of one bit.
  function automatic int cnt_width(input int read_lat, input int write_lat);
    int m;
    m = (read_lat > write_lat) ? read_lat : write_lat;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  localparam int OFF_W = off_width(WORDS_PER_BLOCK_DEF);
  localparam int BLK_W = WORD_W_DEF * WORDS_PER_BLOCK_DEF;
  localparam int BE_W  = WORD_W_DEF / 8;
  localparam int CNT_W = cnt_width(READ_LAT_DEF, WRITE_LAT_DEF);

endpackage

// File: rtl/main_mem_array.sv
// main_mem_array
//   2^ADDR_W blocks x WORDS_PER_BLOCK words of storage, organised as one
//   RAM per word lane so each lane maps onto its own block RAM.
//   Ports:
//     clk        : clock, rising edge
//     wr_en      : write the word selected by wr_addr/wr_offset
//     wr_addr    : block address for the write
//     wr_offset  : word within the block for the write
//     wr_data    : write data
//     wr_be      : per-byte write enables
//     rd_addr    : block address for the read (sampled every edge)
//     rd_block   : registered full-block read data, word 0 in the LSBs
//   Contents start at zero and are never cleared afterwards.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int WORD_W          = WORD_W_DEF,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
  input  logic                                    clk,
  input  logic                                    wr_en,
  input  logic [ADDR_W-1:0]                       wr_addr,
  input  logic [off_width(WORDS_PER_BLOCK)-1:0]   wr_offset,
  input  logic [WORD_W-1:0]                       wr_data,
  input  logic [WORD_W/8-1:0]                     wr_be,
  input  logic [ADDR_W-1:0]                       rd_addr,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0]       rd_block
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LOFF_W = off_width(WORDS_PER_BLOCK);
  localparam int LBE_W  = WORD_W / 8;

  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_lane
    logic [WORD_W-1:0] lane_mem [DEPTH] = '{default: '0};
    logic [WORD_W-1:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_offset == LOFF_W'(gi))) begin
        for (int b = 0; b < LBE_W; b++) begin
          if (wr_be[b]) begin
            lane_mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
      lane_rd_reg <= lane_mem[rd_addr];
    end

    assign rd_block[gi*WORD_W +: WORD_W] = lane_rd_reg;
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl
//   Multi-cycle main memory sitting behind the data cache controller.
//   Services block refills (MsRead) and byte-enabled word stores (MsWrite)
//   after fixed latencies, then pulses MsReady for one cycle.
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     MsRead     : block read request (level, held until MsReady)
//     MsWrite    : word write request (level, held until MsReady)
//     ms_addr    : block address
//     ms_offset  : word within block (writes)
//     ms_wdata   : write data
//     ms_be      : write byte enables
//     MsReady    : one-cycle completion pulse
//     ms_rdata   : block returned by the last completed read
//     busy       : high whenever the controller is not idle
//   Timing: a request accepted on edge k completes on edge k+LAT, where
//   MsReady rises, the write lands in the array, or ms_rdata loads. The
//   following cycle is a RELEASE cycle in which requests are ignored.
module main_memory_ctrl
  import main_mem_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int WORD_W          = WORD_W_DEF,
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int READ_LAT        = READ_LAT_DEF,
  parameter int WRITE_LAT       = WRITE_LAT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  MsRead,
  input  logic                                  MsWrite,
  input  logic [ADDR_W-1:0]                     ms_addr,
  input  logic [off_width(WORDS_PER_BLOCK)-1:0] ms_offset,
  input  logic [WORD_W-1:0]                     ms_wdata,
  input  logic [WORD_W/8-1:0]                   ms_be,
  output logic                                  MsReady,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0]     ms_rdata,
  output logic                                  busy
);

  localparam int LOFF_W  = off_width(WORDS_PER_BLOCK);
  localparam int LBLK_W  = WORD_W * WORDS_PER_BLOCK;
  localparam int LBE_W   = WORD_W / 8;
  localparam int LCNT_W  = cnt_width(READ_LAT, WRITE_LAT);
  localparam logic [LCNT_W-1:0] RD_INIT = LCNT_W'(READ_LAT - 1);
  localparam logic [LCNT_W-1:0] WR_INIT = LCNT_W'(WRITE_LAT - 1);

  state_t              state_reg;
  logic [LCNT_W-1:0]   cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LOFF_W-1:0]   offset_reg;
  logic [WORD_W-1:0]   wdata_reg;
  logic [LBE_W-1:0]    be_reg;

  logic                arr_wr_en;
  logic [ADDR_W-1:0]   arr_rd_addr;
  logic [LBLK_W-1:0]   arr_rd_block;

  // The write lands on the same edge the state leaves WR_WAIT.
  assign arr_wr_en = (state_reg == WR_WAIT) && (cnt_reg == '0);

  // The array read is registered, so the block must be addressed one edge
  // before completion. While idle the live address is used: with
  // READ_LAT=1 the completion edge directly follows the acceptance edge.
  // No write can be in flight during a read, so reading every cycle is safe.
  assign arr_rd_addr = (state_reg == IDLE) ? ms_addr : addr_reg;

  main_mem_array #(
    .ADDR_W          (ADDR_W),
    .WORD_W          (WORD_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
  ) u_array (
    .clk       (clk),
    .wr_en     (arr_wr_en),
    .wr_addr   (addr_reg),
    .wr_offset (offset_reg),
    .wr_data   (wdata_reg),
    .wr_be     (be_reg),
    .rd_addr   (arr_rd_addr),
    .rd_block  (arr_rd_block)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      offset_reg <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
      MsReady    <= 1'b0;
      busy       <= 1'b0;
      ms_rdata   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          MsReady <= 1'b0;
          // Write has priority so a read issued alongside it sees the new
          // data; the read stays pending because the requester holds it.
          if (MsWrite || MsRead) begin
            addr_reg   <= ms_addr;
            offset_reg <= ms_offset;
            wdata_reg  <= ms_wdata;
            be_reg     <= ms_be;
            busy       <= 1'b1;
            if (MsWrite) begin
              state_reg <= WR_WAIT;
              cnt_reg   <= WR_INIT;
            end else begin
              state_reg <= RD_WAIT;
              cnt_reg   <= RD_INIT;
            end
          end
        end

        RD_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RELEASE;
            MsReady   <= 1'b1;
            ms_rdata  <= arr_rd_block;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        WR_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RELEASE;
            MsReady   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        RELEASE: begin
          // Requests are ignored here: the cache is still dropping the
          // request it just had answered.
          state_reg <= IDLE;
          MsReady   <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          MsReady   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
module tb_main_memory_ctrl;

  localparam int RL = 4;
  localparam int WL = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         MsRead = 1'b0;
  logic         MsWrite = 1'b0;
  logic [7:0]   ms_addr = '0;
  logic [1:0]   ms_offset = '0;
  logic [31:0]  ms_wdata = '0;
  logic [3:0]   ms_be = '0;
  logic         MsReady;
  logic [127:0] ms_rdata;
  logic         busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  main_memory_ctrl #(
    .ADDR_W(8), .WORD_W(32), .WORDS_PER_BLOCK(4), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk(clk), .rst(rst), .MsRead(MsRead), .MsWrite(MsWrite),
    .ms_addr(ms_addr), .ms_offset(ms_offset), .ms_wdata(ms_wdata),
    .ms_be(ms_be), .MsReady(MsReady), .ms_rdata(ms_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Timeline view: an accepted op finishes exactly LAT edges later; the
  // next acceptance is possible two edges after completion.
  logic [31:0]  mmem [256][4];
  bit           m_active = 1'b0;
  bit           m_is_wr;
  logic [7:0]   m_addr;
  logic [1:0]   m_off;
  logic [31:0]  m_wd;
  logic [3:0]   m_be;
  int           edge_n = 0;
  int           done_edge = 0;
  int           next_ok = 0;
  logic         exp_ready = 1'b0;
  logic         exp_busy = 1'b0;
  logic [127:0] exp_rdata = '0;

  initial begin
    for (int a = 0; a < 256; a++)
      for (int w = 0; w < 4; w++) mmem[a][w] = '0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active  = 1'b0;
      edge_n    = 0;
      next_ok   = 0;
      exp_ready = 1'b0;
      exp_busy  = 1'b0;
      exp_rdata = '0;
    end else begin
      edge_n++;
      exp_ready = 1'b0;
      if (m_active) begin
        if (edge_n == done_edge) begin
          if (m_is_wr) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) mmem[m_addr][m_off][b*8 +: 8] = m_wd[b*8 +: 8];
            $display("[TB] write addr=%02h off=%0d data=%08h be=%h done", m_addr, m_off, m_wd, m_be);
          end else begin
            for (int w = 0; w < 4; w++) exp_rdata[w*32 +: 32] = mmem[m_addr][w];
            $display("[TB] read  addr=%02h block=%h done", m_addr, exp_rdata);
          end
          exp_ready = 1'b1;
          m_active  = 1'b0;
          next_ok   = edge_n + 2;
        end
      end else if (edge_n >= next_ok && (MsWrite || MsRead)) begin
        m_active  = 1'b1;
        m_is_wr   = MsWrite;
        m_addr    = ms_addr;
        m_off     = ms_offset;
        m_wd      = ms_wdata;
        m_be      = ms_be;
        done_edge = edge_n + (MsWrite ? WL : RL);
      end
      exp_busy = m_active || exp_ready;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", {127'b0, MsReady}, {127'b0, exp_ready});
      check("cyc_busy", {127'b0, busy}, {127'b0, exp_busy});
      check("cyc_rdata", ms_rdata, exp_rdata);
    end
  end

  // Drive one request starting from idle; n = negedges until MsReady seen,
  // so the latency from the acceptance edge is n-1.
  task automatic run_op(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [1:0] o, input logic [31:0] wd,
                        input logic [3:0] be, input int withdraw_at,
                        output int n);
    MsRead = rd; MsWrite = wr; ms_addr = a; ms_offset = o; ms_wdata = wd; ms_be = be;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (MsReady === 1'b1) break;
      if (n == 1) begin
        ms_addr = 8'($urandom); ms_offset = 2'($urandom);
        ms_wdata = $urandom; ms_be = 4'($urandom);
      end
      if (withdraw_at != 0 && n == withdraw_at) begin
        MsRead = 1'b0; MsWrite = 1'b0;
      end
      if (n >= 30) begin
        tests++; fails++;
        $display("FAIL timeout: no MsReady after %0d cycles, required within %0d", n, RL + 1);
        break;
      end
    end
    MsRead = 1'b0; MsWrite = 1'b0;
    @(negedge clk);
  endtask

  int n, p1, p2, pulses, first_pulse;

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", {127'b0, MsReady}, 128'd0);
    check("reset_busy", {127'b0, busy}, 128'd0);
    check("reset_rdata", ms_rdata, 128'd0);

    // Read of an untouched block.
    run_op(1, 0, 8'h25, 2'd0, 32'h0, 4'h0, 0, n);
    check("rd_latency", 128'(n - 1), 128'd4);
    check("rd_zero_block", ms_rdata, 128'd0);

    // Full-word write then read back.
    run_op(0, 1, 8'h25, 2'd2, 32'hDEADBEEF, 4'hF, 0, n);
    check("wr_latency", 128'(n - 1), 128'd3);
    run_op(1, 0, 8'h25, 2'd0, 32'h0, 4'h0, 0, n);
    check("rd_after_wr", ms_rdata, 128'h00000000_DEADBEEF_00000000_00000000);

    // Partial byte-enable write.
    run_op(0, 1, 8'h25, 2'd2, 32'h12345678, 4'b0011, 0, n);
    run_op(1, 0, 8'h25, 2'd0, 32'h0, 4'h0, 0, n);
    check("be_partial", {96'b0, ms_rdata[95:64]}, 128'h DEAD5678);

    // Simultaneous read and write: write first, read afterwards.
    MsRead = 1'b1; MsWrite = 1'b1; ms_addr = 8'h10; ms_offset = 2'd0;
    ms_wdata = 32'hA5A5A5A5; ms_be = 4'hF;
    p1 = 0; p2 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (MsReady === 1'b1) begin
        if (p1 == 0) begin
          p1 = k; MsWrite = 1'b0;
        end else begin
          p2 = k; break;
        end
      end
    end
    MsRead = 1'b0;
    @(negedge clk);
    check("both_wr_latency", 128'(p1 - 1), 128'd3);
    check("both_rd_pulse_at", 128'(p2), 128'd10);
    check("both_word0", {96'b0, ms_rdata[31:0]}, 128'h A5A5A5A5);

    // Held read: one pulse per LAT+2 edges, none re-accepted in RELEASE.
    MsRead = 1'b1; ms_addr = 8'h10;
    pulses = 0; first_pulse = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (MsReady === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = k;
      end
    end
    MsRead = 1'b0;
    repeat (2) @(negedge clk);
    check("held_pulse_count", 128'(pulses), 128'd3);
    check("held_first_pulse", 128'(first_pulse), 128'd5);

    // Reset in the middle of a write aborts it.
    run_op(0, 1, 8'h07, 2'd0, 32'h11111111, 4'hF, 0, n);
    MsWrite = 1'b1; ms_addr = 8'h07; ms_offset = 2'd0; ms_wdata = 32'h22222222; ms_be = 4'hF;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    MsWrite = 1'b0;
    #1;
    check("midrst_ready", {127'b0, MsReady}, 128'd0);
    check("midrst_busy", {127'b0, busy}, 128'd0);
    @(negedge clk);
    check("midrst_ready_hold", {127'b0, MsReady}, 128'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run_op(1, 0, 8'h07, 2'd0, 32'h0, 4'h0, 0, n);
    check("midrst_no_write", {96'b0, ms_rdata[31:0]}, 128'h 11111111);

    // Randomized traffic against the model.
    for (int i = 0; i < 120; i++) begin
      int op, wd_at;
      op = $urandom_range(0, 4);
      wd_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_op(op == 0 || op == 1 || op == 4, op == 2 || op == 3 || op == 4,
             8'h40 + 8'($urandom_range(0, 7)), 2'($urandom), $urandom,
             4'($urandom), wd_at, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
